multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  FSM control unit for the multicycle build of our ARM-subset core (shared datapath/ALU/memory).
//  Decodes the latched instruction and sequences one instruction over 3-5 cycles.
//  Owns the NZCV flags register and condition-check gating.
//  Subset: ADD/SUB/AND/ORR/MOV/CMP (reg/imm), LDR/STR (imm), B, BL, BX.
// PARAMETERS
//  W        32  datapath width (pass-through only; no internal W-wide logic)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET        in   1   synchronous, active-high
//  Cond         in   4   Instr[31:28]
//  Op           in   2   Instr[27:26]: 00 DP, 01 MEM, 10 BR
//  Funct        in   6   Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (MEM: [0]=L)
//  Rd           in   4   Instr[15:12]
//  BXField      in   16  Instr[19:4]; BX when Op=00, Funct=010010, BXField=16'hFFF1
//  ALUFlags     in   4   NZCV from the ALU in the current cycle
//  PCWrite      out  1   PC register enable
//  AdrSrc       out  1   0: mem addr = PC, 1: mem addr = ALU result register
//  MemWrite     out  1   data memory write enable
//  IRWrite      out  1   instruction register enable
//  RegWrite     out  1   register file write enable
//  ResultSrc    out  2   00 ALUOut reg, 01 read data, 10 ALU result direct
//  ALUSrcA      out  1   0 RD1, 1 PC
//  ALUSrcB      out  2   00 RD2, 01 ExtImm, 10 constant 4
//  ALUControl   out  4   ADD 0100, SUB 0010, AND 0000, ORR 1100, MOV 1101
//  ImmSrc       out  2   00 imm8, 01 imm12, 10 imm24<<2
//  RegSrc       out  2   [0] RA1=R15, [1] RA2=Rd
//  LinkWr       out  1   1: write-address mux selects R14 (BL)
//  StateOut     out  4   current state encoding (debug)
// BEHAVIOUR
//  States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7,
//   ALUWB 8, BRANCH 9, BXEX 10; unused encodings go to FETCH on the next edge.
//  RESET=1 at an edge: state=FETCH, Flags=0000. Reset mid-instruction aborts it.
//  While RESET=1, PCWrite/MemWrite/RegWrite/IRWrite are forced 0.
//  FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
//  DECODE: ALUSrcA=1, ALUSrcB=10, ADD (R15 reads see PC+8). CondEx is evaluated from Flags.
//   CondEx=0, or instruction outside the subset -> FETCH (NOP, no writes).
//   Otherwise: MEM -> MEMADR; BX -> BXEX; BR -> BRANCH; DP with I=1 -> EXECI; else -> EXECR.
//  MEMADR: ALUSrcB=01, ImmSrc=01, ADD. L=1 -> MEMRD, else MEMWR.
//  MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  MEMWR: AdrSrc=1, MemWrite=1, RegSrc[1]=1 -> FETCH.
//  EXECR/EXECI: ALUControl=cmd; ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI).
//   CMP -> FETCH with no write; others -> ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH. Rd=15 writes go through regfile (no PC redirect).
//  BRANCH: RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1.
//   BL additionally: RegWrite=1, LinkWr=1; writes PC (=PC+4 of BL) to R14. -> FETCH.
//  BXEX: ALUSrcB=00, MOV, ResultSrc=10, PCWrite=1 -> FETCH.
//  Flags update on the edge leaving EXECR/EXECI, only when CondEx=1:
//   ADD/SUB with S=1, and CMP always (S ignored): NZCV <= ALUFlags.
//   AND/ORR/MOV with S=1: NZ <= ALUFlags[3:2]; CV held.
//  Cond codes: 0000 EQ .. 1101 LE per ARM; 1110 AL true; 1111 treated as false.
//  Latency: DP 4, CMP 3, LDR 5, STR 4, B/BL 3, BX 3, skipped or undefined 2 cycles.
//  Outputs not listed for a state are 0.
// STRUCTURE
//  controller_pkg: state encodings, ALU op codes, cond codes, ResultSrc/ImmSrc enums.
//  Sub-module cond_unit: Flags register, CondEx evaluation, FlagWrite gating.
// TESTING
//  Reset mid-LDR (state MEMRD) -> next state FETCH; Flags=0000; no writes during reset.
//  ADD R1,R2,#5 (E2821005) -> states 0,1,7,8; RegWrite=1 only in ALUWB; 4 cycles.
//  CMP with ALUFlags=0100 (Z), then BEQ -> Flags=0100; BEQ reaches BRANCH, PCWrite=1.
//  BNE with Z=1 -> DECODE then FETCH; no PCWrite in the non-FETCH cycle.
//  LDR (E5910004) -> 5 cycles, ResultSrc=01 in MEMWB; STR -> MemWrite=1 exactly once.
//  BL -> RegWrite=1 and LinkWr=1 in BRANCH; BX (E12FFF1E) -> BXEX, MOV, PCWrite=1.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU op codes, condition codes, mux selects and the flag-write rule.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_BXEX   = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_SUB = 4'b0010,
    ALU_ADD = 4'b0100,
    ALU_ORR = 4'b1100,
    ALU_MOV = 4'b1101
  } alu_ctrl_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    RES_ALUOUT     = 2'b00,
    RES_READ_DATA  = 2'b01,
    RES_ALU_RESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_8  = 2'b00,
    IMM_12 = 2'b01,
    IMM_24 = 2'b10
  } imm_src_t;

  typedef enum logic [1:0] {
    SRCB_RD2     = 2'b00,
    SRCB_EXT_IMM = 2'b01,
    SRCB_FOUR    = 2'b10
  } alu_src_b_t;

  localparam logic [1:0]  OP_DP    = 2'b00;
  localparam logic [1:0]  OP_MEM   = 2'b01;
  localparam logic [1:0]  OP_BR    = 2'b10;

  localparam logic [3:0]  CMD_AND  = 4'b0000;
  localparam logic [3:0]  CMD_SUB  = 4'b0010;
  localparam logic [3:0]  CMD_ADD  = 4'b0100;
  localparam logic [3:0]  CMD_CMP  = 4'b1010;
  localparam logic [3:0]  CMD_ORR  = 4'b1100;
  localparam logic [3:0]  CMD_MOV  = 4'b1101;

  localparam logic [5:0]  FUNCT_BX = 6'b010010;
  localparam logic [15:0] BX_FIELD = 16'hFFF1;

  function automatic logic [3:0] alu_for_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_ORR: return ALU_ORR;
      CMD_MOV: return ALU_MOV;
      default: return ALU_AND;
    endcase
  endfunction

  // Bit 1 requests an NZ update, bit 0 a CV update; logical ops keep CV.
  function automatic logic [1:0] flag_request(input logic [3:0] cmd, input logic s_bit);
    case (cmd)
      CMD_CMP:                   return 2'b11;
      CMD_ADD, CMD_SUB:          return s_bit ? 2'b11 : 2'b00;
      CMD_AND, CMD_ORR, CMD_MOV: return s_bit ? 2'b10 : 2'b00;
      default:                   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and ALU flags into the controller, datapath controls out.
interface multicycle_controller_if;

  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [15:0] BXField;
  logic [3:0]  ALUFlags;

  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        LinkWr;
  logic [3:0]  StateOut;

  modport master (
    input  Cond, Op, Funct, Rd, BXField, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, LinkWr, StateOut
  );

  modport slave (
    output Cond, Op, Funct, Rd, BXField, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, LinkWr, StateOut
  );

endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flags register, condition evaluation and flag-write gating.
module cond_unit
  import multicycle_controller_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_req,
  output logic       cond_ex
);

  logic [3:0] flags;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic [1:0] flag_write;

  assign {n_flag, z_flag, c_flag, v_flag} = flags;
  assign flag_write = flag_req & {2{cond_ex}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags <= 4'b0000;
    end else begin
      if (flag_write[1]) flags[3:2] <= alu_flags[3:2];
      if (flag_write[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

  // NV is deliberately treated as never-execute.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z_flag;
      COND_NE: cond_ex = ~z_flag;
      COND_CS: cond_ex = c_flag;
      COND_CC: cond_ex = ~c_flag;
      COND_MI: cond_ex = n_flag;
      COND_PL: cond_ex = ~n_flag;
      COND_VS: cond_ex = v_flag;
      COND_VC: cond_ex = ~v_flag;
      COND_HI: cond_ex = c_flag & ~z_flag;
      COND_LS: cond_ex = ~c_flag | z_flag;
      COND_GE: cond_ex = (n_flag == v_flag);
      COND_LT: cond_ex = (n_flag != v_flag);
      COND_GT: cond_ex = ~z_flag & (n_flag == v_flag);
      COND_LE: cond_ex = z_flag | (n_flag != v_flag);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: decodes the latched instruction and
// sequences the shared datapath over 3-5 cycles per instruction.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int W = 32
) (
  input logic                     CLK,
  input logic                     RESET,
  multicycle_controller_if.master bus
);

  state_t      state, next_state;
  logic        cond_ex;
  logic [1:0]  flag_req;
  logic [3:0]  cmd;
  logic        imm_bit, s_bit, link_bit;
  logic        is_bx, dp_known, mem_known, br_known, is_cmp;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  result_src_t result_src;
  logic        alu_src_a;
  alu_src_b_t  alu_src_b;
  logic [3:0]  alu_control;
  imm_src_t    imm_src;
  logic [1:0]  reg_src;
  logic        link_wr;

  // Rd and W only matter to the datapath; Rd=15 writes need no redirect here.
  logic unused_bits;
  assign unused_bits = ^{bus.Rd, (W > 0)};

  assign cmd      = bus.Funct[4:1];
  assign imm_bit  = bus.Funct[5];
  assign s_bit    = bus.Funct[0];
  assign link_bit = bus.Funct[4];
  assign is_cmp   = (cmd == CMD_CMP);

  assign is_bx     = (bus.Op == OP_DP) && (bus.Funct == FUNCT_BX) && (bus.BXField == BX_FIELD);
  assign dp_known  = (bus.Op == OP_DP) &&
                     (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND ||
                      cmd == CMD_ORR || cmd == CMD_MOV || cmd == CMD_CMP);
  assign mem_known = (bus.Op == OP_MEM) && !bus.Funct[5];
  assign br_known  = (bus.Op == OP_BR) && bus.Funct[5];

  cond_unit u_cond_unit (
    .CLK       (CLK),
    .RESET     (RESET),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_req  (flag_req),
    .cond_ex   (cond_ex)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_AND;
    imm_src     = IMM_8;
    reg_src     = 2'b00;
    link_wr     = 1'b0;
    flag_req    = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write    = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALU_RESULT;
        pc_write    = 1'b1;
        next_state  = S_DECODE;
      end
      // PC+4 is computed again so that R15 reads observe PC+8.
      S_DECODE: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        if (!cond_ex)       next_state = S_FETCH;
        else if (mem_known) next_state = S_MEMADR;
        else if (is_bx)     next_state = S_BXEX;
        else if (br_known)  next_state = S_BRANCH;
        else if (dp_known)  next_state = imm_bit ? S_EXECI : S_EXECR;
      end
      S_MEMADR: begin
        alu_src_b   = SRCB_EXT_IMM;
        imm_src     = IMM_12;
        alu_control = ALU_ADD;
        next_state  = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_READ_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        reg_src   = 2'b10;
      end
      S_EXECR, S_EXECI: begin
        alu_control = alu_for_cmd(cmd);
        if (state == S_EXECI) begin
          alu_src_b = SRCB_EXT_IMM;
          imm_src   = IMM_8;
        end
        flag_req   = flag_request(cmd, s_bit);
        next_state = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        reg_src     = 2'b01;
        alu_src_b   = SRCB_EXT_IMM;
        imm_src     = IMM_24;
        alu_control = ALU_ADD;
        result_src  = RES_ALU_RESULT;
        pc_write    = 1'b1;
        if (link_bit) begin
          reg_write = 1'b1;
          link_wr   = 1'b1;
        end
      end
      S_BXEX: begin
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_MOV;
        result_src  = RES_ALU_RESULT;
        pc_write    = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed for as long as RESET is held.
  assign bus.PCWrite    = pc_write  & ~RESET;
  assign bus.MemWrite   = mem_write & ~RESET;
  assign bus.RegWrite   = reg_write & ~RESET;
  assign bus.IRWrite    = ir_write  & ~RESET;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegSrc     = reg_src;
  assign bus.LinkWr     = link_wr;
  assign bus.StateOut   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller: per-cycle state and
// write-enable checks for each instruction, plus a reset-mid-LDR sequence.
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  multicycle_controller_if bus();

  multicycle_controller #(.W(32)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [31:0]      instr;
    logic [3:0]       alu_flags;
    int               n_cycles;
    logic [0:4][3:0]  states;
    logic [4:0]       pcw;
    logic [4:0]       regw;
    logic [4:0]       memw;
    int               chk_cycle;
    logic [3:0]       alu;
    logic [1:0]       res;
    logic [1:0]       srcb;
    logic [1:0]       imm;
    logic             link;
  } vec_t;

  int   n_compared = 0;
  int   n_failed   = 0;
  vec_t vecs[$];

  function automatic vec_t mkVec(input string name, input logic [31:0] instr,
                                 input logic [3:0] alu_flags, input int n_cycles,
                                 input logic [0:4][3:0] states, input logic [4:0] pcw,
                                 input logic [4:0] regw, input logic [4:0] memw,
                                 input int chk_cycle, input logic [3:0] alu,
                                 input logic [1:0] res, input logic [1:0] srcb,
                                 input logic [1:0] imm, input logic link);
    vec_t v;
    v.name = name;   v.instr = instr; v.alu_flags = alu_flags; v.n_cycles = n_cycles;
    v.states = states; v.pcw = pcw;   v.regw = regw; v.memw = memw;
    v.chk_cycle = chk_cycle; v.alu = alu; v.res = res; v.srcb = srcb; v.imm = imm;
    v.link = link;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] alu_flags);
    bus.Cond     = instr[31:28];
    bus.Op       = instr[27:26];
    bus.Funct    = instr[25:20];
    bus.Rd       = instr[15:12];
    bus.BXField  = instr[19:4];
    bus.ALUFlags = alu_flags;
  endtask

  task automatic checkWritesIdle(input string tag);
    checkOutput({tag, " PCWrite"},  16'(bus.PCWrite),  16'd0);
    checkOutput({tag, " IRWrite"},  16'(bus.IRWrite),  16'd0);
    checkOutput({tag, " RegWrite"}, 16'(bus.RegWrite), 16'd0);
    checkOutput({tag, " MemWrite"}, 16'(bus.MemWrite), 16'd0);
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
  task automatic runVector(input vec_t v);
    applyStimulus(v.instr, v.alu_flags);
    for (int c = 0; c < v.n_cycles; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c%0d state", v.name, c), 16'(bus.StateOut), 16'(v.states[c]));
      checkOutput($sformatf("%s c%0d PCWrite", v.name, c), 16'(bus.PCWrite), 16'(v.pcw[c]));
      checkOutput($sformatf("%s c%0d RegWrite", v.name, c), 16'(bus.RegWrite), 16'(v.regw[c]));
      checkOutput($sformatf("%s c%0d MemWrite", v.name, c), 16'(bus.MemWrite), 16'(v.memw[c]));
      checkOutput($sformatf("%s c%0d IRWrite", v.name, c), 16'(bus.IRWrite), 16'(c == 0));
      if (c == v.chk_cycle) begin
        checkOutput($sformatf("%s ALUControl", v.name), 16'(bus.ALUControl), 16'(v.alu));
        checkOutput($sformatf("%s ResultSrc", v.name), 16'(bus.ResultSrc), 16'(v.res));
        checkOutput($sformatf("%s ALUSrcB", v.name), 16'(bus.ALUSrcB), 16'(v.srcb));
        checkOutput($sformatf("%s ImmSrc", v.name), 16'(bus.ImmSrc), 16'(v.imm));
        checkOutput($sformatf("%s LinkWr", v.name), 16'(bus.LinkWr), 16'(v.link));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Columns: name, instr, ALUFlags, cycles, states, PCWrite/RegWrite/MemWrite
    // masks (bit = cycle), detail cycle, ALUControl, ResultSrc, ALUSrcB, ImmSrc, LinkWr.
    // Flag history: 0000 -> CMP 0100 -> ADDS 1001 -> ANDS 0101 -> MOVS 1001 -> CMP 0010.
    vecs.push_back(mkVec("ADD_IMM",    32'hE2821005, 4'b0000, 4, {4'd0,4'd1,4'd7,4'd8,4'd0},
                         5'b00001, 5'b01000, 5'b00000, 2, 4'b0100, 2'b00, 2'b01, 2'b00, 1'b0));
    vecs.push_back(mkVec("CMP_IMM_Z",  32'hE3510000, 4'b0100, 3, {4'd0,4'd1,4'd7,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 2, 4'b0010, 2'b00, 2'b01, 2'b00, 1'b0));
    vecs.push_back(mkVec("BEQ_TAKEN",  32'h0A000004, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                         5'b00101, 5'b00000, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b0));
    vecs.push_back(mkVec("BNE_SKIP",   32'h1A000004, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("ADDS_REG",   32'hE0933004, 4'b1001, 4, {4'd0,4'd1,4'd6,4'd8,4'd0},
                         5'b00001, 5'b01000, 5'b00000, 2, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("BLGE_TAKEN", 32'hAB000010, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                         5'b00101, 5'b00100, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b1));
    vecs.push_back(mkVec("BLLT_SKIP",  32'hBB000010, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("ANDS_NZ",    32'hE0100000, 4'b0110, 4, {4'd0,4'd1,4'd6,4'd8,4'd0},
                         5'b00001, 5'b01000, 5'b00000, 2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("BCS_SKIP",   32'h2A000001, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("BVS_TAKEN",  32'h6A000001, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                         5'b00101, 5'b00000, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b0));
    vecs.push_back(mkVec("LDR",        32'hE5910004, 4'b0000, 5, {4'd0,4'd1,4'd2,4'd3,4'd4},
                         5'b00001, 5'b10000, 5'b00000, 4, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("STR",        32'hE5810004, 4'b0000, 4, {4'd0,4'd1,4'd2,4'd5,4'd0},
                         5'b00001, 5'b00000, 5'b01000, 2, 4'b0100, 2'b00, 2'b01, 2'b01, 1'b0));
    vecs.push_back(mkVec("BX",         32'hE12FFF1E, 4'b0000, 3, {4'd0,4'd1,4'd10,4'd0,4'd0},
                         5'b00101, 5'b00000, 5'b00000, 2, 4'b1101, 2'b10, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("UNDEF_OP3",  32'hEC000000, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("MOV_NV",     32'hF1A00001, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("MOVS_EQ",    32'h01B00001, 4'b1000, 4, {4'd0,4'd1,4'd6,4'd8,4'd0},
                         5'b00001, 5'b01000, 5'b00000, 2, 4'b1101, 2'b00, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("BMI_TAKEN",  32'h4A000000, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                         5'b00101, 5'b00000, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b0));
    vecs.push_back(mkVec("EOR_UNDEF",  32'hE0200000, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("LDR_REGOFF", 32'hE7910004, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    vecs.push_back(mkVec("CMP_REG",    32'hE1410000, 4'b0010, 3, {4'd0,4'd1,4'd6,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 2, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mkVec("BHI_TAKEN",  32'h8A000000, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                         5'b00101, 5'b00000, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b0));
    vecs.push_back(mkVec("BLS_SKIP",   32'h9A000000, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                         5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));

    applyStimulus(32'h0000_0000, 4'b0000);
    @(negedge clk);
    checkOutput("reset state", 16'(bus.StateOut), 16'd0);
    checkWritesIdle("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) runVector(vecs[i]);

    // Set Z, then abort an LDR in MEMRD; the flags must come back cleared.
    runVector(mkVec("CMP_Z2", 32'hE3510000, 4'b0100, 3, {4'd0,4'd1,4'd7,4'd0,4'd0},
                    5'b00001, 5'b00000, 5'b00000, 2, 4'b0010, 2'b00, 2'b01, 2'b00, 1'b0));
    applyStimulus(32'hE5910004, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ldr pre state", 16'(bus.StateOut), 16'd3);
    reset = 1'b1;
    #1;
    checkWritesIdle("rst_ldr memrd");
    @(negedge clk);
    checkOutput("rst_ldr post state", 16'(bus.StateOut), 16'd0);
    checkWritesIdle("rst_ldr fetch held");
    @(posedge clk);
    #1 reset = 1'b0;
    runVector(mkVec("BEQ_AFTER_RST", 32'h0A000004, 4'b0000, 2, {4'd0,4'd1,4'd0,4'd0,4'd0},
                    5'b00001, 5'b00000, 5'b00000, 1, 4'b0100, 2'b00, 2'b10, 2'b00, 1'b0));
    runVector(mkVec("BNE_AFTER_RST", 32'h1A000004, 4'b0000, 3, {4'd0,4'd1,4'd9,4'd0,4'd0},
                    5'b00001 | 5'b00100, 5'b00000, 5'b00000, 2, 4'b0100, 2'b10, 2'b01, 2'b10, 1'b0));

    @(negedge clk);
    checkOutput("final state", 16'(bus.StateOut), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
